// File: rtl/rr_otf_converter_pkg.sv
// rtl/rr_otf_converter_pkg.sv - shared FSM encoding and width helpers for the on-the-fly converter
package rr_otf_converter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } otf_state_t;

    function automatic int digit_bits(input int radix);
        return $clog2(radix) + 1;
    endfunction

    function automatic int result_bits(input int radix, input int width);
        return $clog2(radix) * (2 * width + 1) + 1;
    endfunction

endpackage

// File: rtl/rr_otf_converter_step.sv
// rtl/rr_otf_converter_step.sv - combinational single-digit Q/QM update
module rr_otf_converter_step #(
    parameter int RADIX = 4,
    parameter int B     = 19
) (
    input  logic [$clog2(RADIX):0] digit,
    input  logic [B-1:0]           q,
    input  logic [B-1:0]           qm,
    output logic [B-1:0]           q_next,
    output logic [B-1:0]           qm_next,
    output logic                   bad
);
    localparam int LR = $clog2(RADIX);

    logic          neg;
    logic          pos;
    logic [LR:0]   digit_m1;
    logic [B-1:0]  q_base;
    logic [B-1:0]  qm_base;

    // The low LR bits of d and d-1 already equal (RADIX+d) and (RADIX-1+d) mod RADIX,
    // so only the choice of Q or QM as the prefix depends on the digit sign.
    assign neg      = digit[LR];
    assign pos      = !neg && (digit != '0);
    assign digit_m1 = digit - {{LR{1'b0}}, 1'b1};
    assign q_base   = neg ? qm : q;
    assign qm_base  = pos ? q : qm;
    assign q_next   = {q_base[B-LR-1:0], digit[LR-1:0]};
    assign qm_next  = {qm_base[B-LR-1:0], digit_m1[LR-1:0]};
    assign bad      = (digit == {1'b1, {LR{1'b0}}});

endmodule

// File: rtl/rr_otf_converter.sv
// rtl/rr_otf_converter.sv - MSD-first signed-digit to two's-complement converter, one digit per clock
module rr_otf_converter
    import rr_otf_converter_pkg::*;
#(
    parameter int  WIDTH = 4,
    parameter int  RADIX = 4,
    localparam int D     = digit_bits(RADIX),
    localparam int NDIG  = 2 * WIDTH + 1,
    localparam int B     = result_bits(RADIX, WIDTH)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [D*NDIG-1:0] p_in,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [B-1:0]    q_out,
    output logic            err,
    output logic            out_valid,
    input  logic            out_ready
);
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

    otf_state_t          state;
    logic [CW-1:0]       cnt;
    logic [D*NDIG-1:0]   sr;
    logic [B-1:0]        q_reg;
    logic [B-1:0]        qm_reg;
    logic [B-1:0]        q_next;
    logic [B-1:0]        qm_next;
    logic                bad;

    rr_otf_converter_step #(
        .RADIX (RADIX),
        .B     (B)
    ) u_step (
        .digit   (sr[D*NDIG-1 -: D]),
        .q       (q_reg),
        .qm      (qm_reg),
        .q_next  (q_next),
        .qm_next (qm_next),
        .bad     (bad)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            q_out     <= '0;
            err       <= 1'b0;
            cnt       <= '0;
            sr        <= '0;
            q_reg     <= '0;
            qm_reg    <= '1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sr       <= p_in;
                        q_reg    <= '0;
                        qm_reg   <= '1;
                        err      <= 1'b0;
                        cnt      <= CW'(NDIG - 1);
                        in_ready <= 1'b0;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    q_reg  <= q_next;
                    qm_reg <= qm_next;
                    err    <= err | bad;
                    sr     <= {sr[D*NDIG-D-1:0], {D{1'b0}}};
                    cnt    <= cnt - 1'b1;
                    if (cnt == '0) begin
                        q_out     <= q_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_otf_converter.sv
// tb/tb_rr_otf_converter.sv - directed and random checks of rr_otf_converter (WIDTH=4, RADIX=4)
module tb_rr_otf_converter;

    localparam int NW = 20;

    logic        clock;
    logic        reset_n;
    logic [26:0] p_in;
    logic        in_valid;
    logic        in_ready;
    logic [18:0] q_out;
    logic        err;
    logic        out_valid;
    logic        out_ready;

    int n_vec = 0;
    int n_bad = 0;
    logic [18:0] exp_q[$];

    rr_otf_converter #(
        .WIDTH (4),
        .RADIX (4)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .p_in      (p_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q_out     (q_out),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [26:0] fill(input logic [2:0] d);
        logic [26:0] w;
        for (int i = 0; i < 9; i++) w[3*i +: 3] = d;
        return w;
    endfunction

    function automatic logic [18:0] ref_sum(input logic [26:0] p);
        logic [18:0] a;
        a = '0;
        for (int i = 8; i >= 0; i--) a = (a << 2) + {{16{p[3*i+2]}}, p[3*i +: 3]};
        return a;
    endfunction

    // Caller is at a negedge; returns at a negedge after the result handshake.
    task automatic run_word(input string tag, input logic [26:0] p, input logic [18:0] eq,
                            input logic ee, input int stall);
        int k;
        int lat;
        in_valid = 1'b1;
        p_in     = p;
        k        = 0;
        while (!in_ready && k < 50) begin
            @(negedge clock);
            k++;
        end
        check({tag, "_accept"}, 32'(in_ready), 32'd1);
        @(negedge clock);
        in_valid = 1'b0;
        if (stall > 0) out_ready = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd10);
        check({tag, "_q"}, 32'(q_out), 32'(eq));
        check({tag, "_err"}, 32'(err), 32'(ee));
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            check({tag, "_hold_q"}, 32'(q_out), 32'(eq));
            check({tag, "_hold_v"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clock);
        check({tag, "_drain_v"}, 32'(out_valid), 32'd0);
        check({tag, "_drain_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [26:0] w;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        p_in      = '0;
        repeat (2) @(negedge clock);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_q_out", 32'(q_out), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        run_word("zero", '0, 19'd0, 1'b0, 0);
        w = '0; w[2:0] = 3'b001;
        run_word("d0_p1", w, 19'd1, 1'b0, 0);
        w = '0; w[2:0] = 3'b111;
        run_word("d0_m1", w, 19'h7FFFF, 1'b0, 0);
        w = fill(3'b111); w[26:24] = 3'b001;
        run_word("msd_p1", w, 19'd43691, 1'b0, 0);
        w = fill(3'b011); w[26:24] = 3'b101;
        run_word("msd_m3", w, 19'd393215, 1'b0, 0);
        w = fill(3'b011); w[26:24] = 3'b111;
        run_word("msd_m1", w, 19'h7FFFF, 1'b0, 0);
        w = fill(3'b001);
        run_word("stall", w, 19'd87381, 1'b0, 5);
        w = '0; w[14:12] = 3'b100;
        run_word("bad_digit", w, 19'd523264, 1'b1, 0);

        // Asynchronous reset in the middle of a conversion.
        in_valid = 1'b1;
        p_in     = fill(3'b010);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (4) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_q_out", 32'(q_out), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        run_word("after_rst", fill(3'b010), 19'd174762, 1'b0, 0);

        // Random legal words with gaps on the input and random backpressure.
        fork
            begin
                for (int n = 0; n < NW; n++) begin
                    int k;
                    logic [26:0] r;
                    repeat ($urandom_range(0, 2)) @(negedge clock);
                    for (int i = 0; i < 9; i++) r[3*i +: 3] = 3'($urandom_range(0, 6) - 3);
                    in_valid = 1'b1;
                    p_in     = r;
                    k        = 0;
                    while (!in_ready && k < 200) begin
                        @(negedge clock);
                        k++;
                    end
                    if (in_ready) exp_q.push_back(ref_sum(r));
                    else check("rnd_accept", 32'(in_ready), 32'd1);
                    @(negedge clock);
                    in_valid = 1'b0;
                end
            end
            begin
                int got;
                int cyc;
                logic [18:0] e;
                got = 0;
                cyc = 0;
                while (got < NW && cyc < 4000) begin
                    @(negedge clock);
                    cyc++;
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("rnd_dup", 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check("rnd_q", 32'(q_out), 32'(e));
                            check("rnd_err", 32'(err), 32'd0);
                        end
                        got++;
                    end
                end
                check("rnd_count", 32'(got), 32'(NW));
                @(negedge clock);
                out_ready = 1'b1;
            end
        join
        check("rnd_left", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
